dense_layer_backward: RTL and testbench
=======================================

// Module: dense_layer_backward
// PURPOSE
//  Backward (gradient) pass for a ReLU dense layer: given the layer's forward ReLU
//  outputs and the upstream gradient, computes the input gradient
//  grad_in[i] = sum_j W[i][j]*delta[j] and the bias gradient delta[j].
//  delta[j] = grad_out[j] if fwd_out[j] != 0, else 0.
//  Time-multiplexes one NBits multiplier over D1*D2 cycles.
//  Sits between successive layers' backward stages, with valid/ready on both sides.
// PARAMETERS
//  NBits  16  word width; two's-complement, same format as the forward dense layer
//  T      logic [NBits-1:0]  element type
//  D1     none (required)  layer input width; must be >= 1
//  D2     none (required)  layer output width; must be >= 1
// PORTS
//  clk        in   1          clock, rising edge
//  rst        in   1          reset; asynchronous, active-high
//  in_valid   in   1          grad_out/fwd_out/weights valid
//  in_ready   out  1          block idle, can accept
//  grad_out   in   T [D2]     upstream gradient (dL/d dout)
//  fwd_out    in   T [D2]     forward-pass ReLU outputs of this layer
//  weights    in   T [D1][D2] layer weights; read live, not captured
//  out_valid  out  1          grad_in/bias_grad valid
//  out_ready  in   1          consumer accepts result
//  grad_in    out  T [D1]     dL/d din
//  bias_grad  out  T [D2]     dL/d bias (= masked delta)
// BEHAVIOUR
//  - Reset: state IDLE; in_ready=1; out_valid=0; grad_in, bias_grad, counters = '0.
//  - FSM: IDLE -> MAC -> DONE -> IDLE.
//  - IDLE: in_ready=1.
//    On in_valid && in_ready:
//      capture delta[j] = (fwd_out[j] != '0) ? grad_out[j] : '0 into bias_grad;
//      clear grad_in to '0; set i=0, j=0; go to MAC.
//  - MAC: in_ready=0. Each cycle: grad_in[i] <= grad_in[i] + W[i][j]*bias_grad[j].
//    The product is truncated to the low NBits; the sum wraps modulo 2^NBits.
//    No saturation. Iteration order: j inner, i outer.
//    At i=D1-1, j=D2-1, after that accumulate -> DONE.
//  - Latency: accept at edge k; out_valid=1 after edge k+D1*D2.
//  - DONE: out_valid=1; outputs held stable while out_ready=0.
//    in_valid is ignored (in_ready=0).
//    On out_valid && out_ready -> IDLE; out_valid drops after that edge.
//    The next accept is possible one cycle later.
//    Results stay in grad_in/bias_grad until the next accept.
//  - weights must be stable from the accept edge until out_valid.
//    grad_out and fwd_out are don't-care after the accept edge.
//  - Counter widths are $clog2(D) with a minimum of 1. D1=1 or D2=1 must work:
//    D1=D2=1 gives a 1-cycle MAC.
//  - rst asserted in any state (incl. mid-MAC or DONE): immediate return to reset values.
//    The partial result is discarded; no out_valid pulse is produced.
//  - All-zero fwd_out: delta=0, grad_in all '0. The full D1*D2 latency is still taken.
// TESTING
//  1 Basic, D1=D2=2, NBits=16: W=[[1,2],[3,4]], grad_out=[1,1], fwd_out=[5,7]
//    -> grad_in=[3,7], bias_grad=[1,1], out_valid 4 cycles after accept.
//  2 ReLU mask: same W and grad_out, fwd_out=[0,7] -> grad_in=[2,4], bias_grad=[0,1].
//  3 Signed/wrap: D1=D2=1, W=16'h0003, grad_out=16'hFFFF, fwd_out=1 -> grad_in=16'hFFFD.
//    Then W=16'h4000, grad_out=4 -> grad_in=16'h0000.
//  4 Backpressure: out_ready=0 for 5 cycles in DONE while in_valid=1
//    -> out_valid held, outputs unchanged, in_ready=0, no new accept.
//    Raise out_ready -> one handshake, then in_ready=1.
//  5 Reset mid-MAC (test 1 stimulus, rst at MAC cycle 2)
//    -> outputs '0, in_ready=1, out_valid never pulses.
//    A re-issued test 1 then gives [3,7].
//  6 Back-to-back: in_valid and out_ready tied high, 3 different vectors
//    -> 3 correct results, each D1*D2 cycles after its accept.

Source files
------------

// File: rtl/dense_layer_backward.sv
// dense_layer_backward: ReLU dense-layer backward pass, one shared multiplier stepped over D1*D2 cycles.
module dense_layer_backward #(
  parameter int NBits = 16,
  parameter int D1    = 2,
  parameter int D2    = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [D2-1:0][NBits-1:0]           grad_out,
  input  logic [D2-1:0][NBits-1:0]           fwd_out,
  input  logic [D1-1:0][D2-1:0][NBits-1:0]   weights,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [D1-1:0][NBits-1:0]           grad_in,
  output logic [D2-1:0][NBits-1:0]           bias_grad
);
  localparam int IW = D1 > 1 ? $clog2(D1) : 1;
  localparam int JW = D2 > 1 ? $clog2(D2) : 1;
  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
  state_t state, next;
  logic [IW-1:0] i;
  logic [JW-1:0] j;
  logic last_i, last_j;
  logic [NBits-1:0] prod;
  assign last_i = i == IW'(D1 - 1);
  assign last_j = j == JW'(D2 - 1);
  // bias_grad doubles as the captured delta vector feeding the multiplier
  assign prod = weights[i][j] * bias_grad[j];
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  always_comb
    next = state == IDLE ? (in_valid ? MAC : IDLE) :
           state == MAC  ? (last_i && last_j ? DONE : MAC) :
           (out_ready ? IDLE : DONE);
  always_comb begin
    in_ready  = state == IDLE;
    out_valid = state == DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      grad_in   <= '0;
      bias_grad <= '0;
      i         <= '0;
      j         <= '0;
    end else if (state == IDLE && in_valid) begin
      for (int k = 0; k < D2; k++) bias_grad[k] <= fwd_out[k] != '0 ? grad_out[k] : '0;
      grad_in <= '0;
      i       <= '0;
      j       <= '0;
    end else if (state == MAC) begin
      grad_in[i] <= grad_in[i] + prod;
      j          <= last_j ? '0 : j + 1'b1;
      if (last_j) i <= last_i ? '0 : i + 1'b1;
    end
endmodule

// File: tb/tb_dense_layer_backward.sv
// tb_dense_layer_backward: directed vector table on a 2x2 instance plus hand sequences on 2x2 and 1x1.
module tb_dense_layer_backward;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [1:0][15:0] a_g, a_f, a_gi, a_bg;
  logic [1:0][1:0][15:0] a_w;
  logic b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [0:0][15:0] b_g, b_f, b_gi, b_bg;
  logic [0:0][0:0][15:0] b_w;
  dense_layer_backward #(.NBits(16), .D1(2), .D2(2)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .grad_out(a_g), .fwd_out(a_f), .weights(a_w), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .grad_in(a_gi), .bias_grad(a_bg));
  dense_layer_backward #(.NBits(16), .D1(1), .D2(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .grad_out(b_g), .fwd_out(b_f), .weights(b_w), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .grad_in(b_gi), .bias_grad(b_bg));
  typedef struct {
    logic [1:0][1:0][15:0] w;
    logic [1:0][15:0] g, f, gi, bg;
  } vec_t;
  vec_t tv[5];
  int errors = 0, checks = 0;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic [15:0] w00, w01, w10, w11, g0, g1, f0, f1, e0, e1, b0, b1);
    vec_t v;
    v.w[0][0] = w00; v.w[0][1] = w01; v.w[1][0] = w10; v.w[1][1] = w11;
    v.g[0] = g0; v.g[1] = g1; v.f[0] = f0; v.f[1] = f1;
    v.gi[0] = e0; v.gi[1] = e1; v.bg[0] = b0; v.bg[1] = b1;
    return v;
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_a(output int lat);
    lat = 0;
    while (!a_out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask
  task automatic run_a(input vec_t v, input string n);
    int lat;
    chk({n, " in_ready"}, a_in_ready, 1);
    a_w = v.w; a_g = v.g; a_f = v.f; a_in_valid = 1;
    tick();
    a_in_valid = 0; a_g = '1; a_f = '1;
    wait_a(lat);
    chk({n, " latency"}, lat, 4);
    chk({n, " grad_in"}, a_gi, v.gi);
    chk({n, " bias_grad"}, a_bg, v.bg);
    a_out_ready = 1;
    tick();
    a_out_ready = 0;
    chk({n, " out_valid drop"}, a_out_valid, 0);
  endtask
  task automatic run_b(input logic [15:0] w, g, f, e, input string n);
    int lat = 0;
    b_w = w; b_g = g; b_f = f; b_in_valid = 1;
    tick();
    b_in_valid = 0; b_g = '0; b_f = '0;
    while (!b_out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({n, " latency"}, lat, 1);
    chk({n, " grad_in"}, b_gi, e);
    b_out_ready = 1;
    tick();
    b_out_ready = 0;
  endtask
  initial begin
    int lat, guard;
    logic seen;
    tv[0] = mk(1, 2, 3, 4, 1, 1, 5, 7, 3, 7, 1, 1);
    tv[1] = mk(1, 2, 3, 4, 1, 1, 0, 7, 2, 4, 0, 1);
    tv[2] = mk(1, 2, 3, 4, 9, 9, 0, 0, 0, 0, 0, 0);
    tv[3] = mk(16'hFFFF, 2, 5, 16'hFFFD, 2, 16'hFFFC, 1, 16'hFFFF, 16'hFFF6, 16'h0016, 2, 16'hFFFC);
    tv[4] = mk(16'h7FFF, 16'h7FFF, 16'h0100, 16'h0100, 2, 1, 1, 1, 16'h7FFD, 16'h0300, 2, 1);
    a_in_valid = 0; a_out_ready = 0; a_g = '0; a_f = '0; a_w = '0;
    b_in_valid = 0; b_out_ready = 0; b_g = '0; b_f = '0; b_w = '0;
    tick();
    chk("reset in_ready", a_in_ready, 1);
    chk("reset out_valid", a_out_valid, 0);
    chk("reset grad_in", a_gi, 0);
    chk("reset bias_grad", a_bg, 0);
    rst = 0;
    tick();
    for (int k = 0; k < 5; k++) run_a(tv[k], $sformatf("vec%0d", k));
    run_b(16'h0003, 16'hFFFF, 16'h0001, 16'hFFFD, "1x1 signed");
    run_b(16'h4000, 16'h0004, 16'h0001, 16'h0000, "1x1 wrap");
    // backpressure: hold DONE while a new request waits
    a_w = tv[0].w; a_g = tv[0].g; a_f = tv[0].f; a_in_valid = 1;
    tick();
    a_in_valid = 0;
    wait_a(lat);
    chk("bp latency", lat, 4);
    a_in_valid = 1; a_g = tv[1].g; a_f = tv[1].f;
    repeat (5) begin
      tick();
      chk("bp out_valid", a_out_valid, 1);
      chk("bp in_ready", a_in_ready, 0);
      chk("bp grad_in", a_gi, tv[0].gi);
      chk("bp bias_grad", a_bg, tv[0].bg);
    end
    a_out_ready = 1; a_in_valid = 0;
    tick();
    a_out_ready = 0;
    chk("bp after out_valid", a_out_valid, 0);
    chk("bp after in_ready", a_in_ready, 1);
    chk("bp held grad_in", a_gi, tv[0].gi);
    // reset in the middle of the MAC sweep
    a_w = tv[0].w; a_g = tv[0].g; a_f = tv[0].f; a_in_valid = 1;
    tick();
    a_in_valid = 0;
    tick();
    rst = 1;
    #1;
    chk("rst grad_in", a_gi, 0);
    chk("rst bias_grad", a_bg, 0);
    chk("rst in_ready", a_in_ready, 1);
    tick();
    rst = 0;
    seen = 0;
    repeat (8) begin
      tick();
      seen |= a_out_valid;
    end
    chk("rst no out_valid", seen, 0);
    run_a(tv[0], "after rst");
    // back-to-back with both handshakes held high
    a_out_ready = 1; a_in_valid = 1;
    for (int k = 1; k < 4; k++) begin
      a_w = tv[k].w; a_g = tv[k].g; a_f = tv[k].f;
      guard = 0;
      while (!a_in_ready && guard < 10) begin
        tick();
        guard++;
      end
      chk($sformatf("b2b%0d ready", k), a_in_ready, 1);
      tick();
      wait_a(lat);
      chk($sformatf("b2b%0d latency", k), lat, 4);
      chk($sformatf("b2b%0d grad_in", k), a_gi, tv[k].gi);
      chk($sformatf("b2b%0d bias_grad", k), a_bg, tv[k].bg);
      tick();
    end
    a_out_ready = 0; a_in_valid = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
